// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: instruction-fetch and PC sequencing stage.
// Holds the architectural PC and fetches one instruction per commit over a
// req/ack instruction-memory interface. It presents the held word to decode
// and computes the next PC from the pc_src select. A misaligned target or a
// fetch timeout halts fetch in a sticky trap that only reset clears.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   pc_src               next-PC select: 00 pc+4, 01 pc+imm_ext, 10 jalr, 11 pc+4
//   imm_ext, alu_result  branch/jal immediate, jalr target
//   exec_done            current instruction committed; advance the PC
//   imem_req, imem_addr  fetch request and address (imem_addr mirrors pc)
//   imem_ack, imem_rdata fetch data strobe and instruction word
//   instr, instr_valid   held instruction to decode and its valid flag
//   pc, pc_plus4         current PC and pc+4 (combinational)
//   trap, trap_cause     sticky halt flag; 01 misaligned, 10 imem timeout
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  pc_src,
  input  logic [31:0] imm_ext,
  input  logic [31:0] alu_result,
  input  logic        exec_done,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        trap,
  output logic [1:0]  trap_cause
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_VALID, S_TRAP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      next_pc;
  logic             unused_alu_bit0;

  // jalr clears bit 0 of the target, so alu_result[0] never reaches the PC
  assign unused_alu_bit0 = alu_result[0];

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;

  // Next-PC select; the reserved encoding falls back to sequential
  always_comb begin
    next_pc = pc_plus4;
    case (pc_src)
      2'b01:   next_pc = pc + imm_ext;
      2'b10:   next_pc = {alu_result[31:1], 1'b0};
      default: next_pc = pc_plus4;
    endcase
  end

  // Fetch sequencer with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      instr       <= 32'h0;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
      trap        <= 1'b0;
      trap_cause  <= 2'b00;
      cnt         <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          state    <= S_REQ;
          imem_req <= 1'b1;
          cnt      <= '0;
        end
        S_REQ: begin
          if (imem_ack) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            cnt         <= '0;
            state       <= S_VALID;
          end else if (cnt == CNT_LAST) begin
            imem_req   <= 1'b0;
            trap       <= 1'b1;
            trap_cause <= CAUSE_TIMEOUT;
            state      <= S_TRAP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_VALID: begin
          if (exec_done) begin
            instr_valid <= 1'b0;
            // The committing instruction stands; only the bad target is refused
            if (next_pc[1:0] != 2'b00) begin
              trap       <= 1'b1;
              trap_cause <= CAUSE_MISALIGN;
              state      <= S_TRAP;
            end else begin
              pc       <= next_pc;
              imem_req <= 1'b1;
              cnt      <= '0;
              state    <= S_REQ;
            end
          end
        end
        default: begin
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  pc_src = 2'b00;
  logic [31:0] imm_ext = 32'h0;
  logic [31:0] alu_result = 32'h0;
  logic        exec_done = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        trap;
  logic [1:0]  trap_cause;

  logic ack_auto = 1'b1;
  logic ack_force = 1'b0;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h0050_0093;
  endfunction

  // Memory model: acks any request at once when enabled; a forced ack
  // returns a marker word so a wrongly accepted ack is visible
  assign imem_ack   = ack_force | (ack_auto & imem_req);
  assign imem_rdata = ack_force ? 32'hDEAD_BEEF : mem_word(imem_addr);

  fetch_pc_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .pc_src(pc_src), .imm_ext(imm_ext),
    .alu_result(alu_result), .exec_done(exec_done), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4),
    .trap(trap), .trap_cause(trap_cause)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cyc++;
      if (instr_valid) break;
    end
    if (!instr_valid) cyc = 99;
  endtask

  // Drive one exec_done pulse; returns at the negedge after the commit edge
  task automatic pulse(input logic [1:0] src, input logic [31:0] imm, input logic [31:0] alu);
    pc_src = src; imm_ext = imm; alu_result = alu; exec_done = 1'b1;
    @(posedge clk);
    @(negedge clk);
    exec_done = 1'b0;
  endtask

  // Pop the next expected fetch and compare against what decode sees
  task automatic sb_pop(input string name);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s_sb: got output with empty scoreboard, required queued entry", name);
    end else begin
      e = exp_q.pop_front();
      check({name, "_pc"}, pc, e);
      check({name, "_instr"}, instr, mem_word(e));
    end
  endtask

  task automatic step(input string name, input logic [1:0] src, input logic [31:0] imm,
                      input logic [31:0] alu, input logic [31:0] exp_pc);
    int cyc;
    pulse(src, imm, alu);
    check({name, "_pc_next"}, pc, exp_pc);
    check({name, "_addr"}, imem_addr, exp_pc);
    check({name, "_req"}, 32'(imem_req), 32'd1);
    exp_q.push_back(exp_pc);
    wait_valid(cyc);
    check({name, "_latency"}, 32'(cyc), 32'd1);
    sb_pop(name);
  endtask

  typedef struct {
    string       name;
    logic [1:0]  src;
    logic [31:0] imm;
    logic [31:0] alu;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int cyc;
    int req_cycles;
    vecs[0] = '{"jal_0x10",   2'b01, 32'h0000_0010, 32'h0,          32'h0000_0010};
    vecs[1] = '{"seq_00",     2'b00, 32'h0,         32'h0,          32'h0000_0014};
    vecs[2] = '{"jalr_bit0",  2'b10, 32'h0,         32'h0000_0011,  32'h0000_0010};
    vecs[3] = '{"seq_11",     2'b11, 32'h0000_0100, 32'h0000_0200,  32'h0000_0014};
    vecs[4] = '{"jalr_0x100", 2'b10, 32'h0,         32'h0000_0100,  32'h0000_0100};
    vecs[5] = '{"branch_neg", 2'b01, 32'hFFFF_FFF0, 32'h0,          32'h0000_00F0};
    vecs[6] = '{"jalr_0x101", 2'b10, 32'h0,         32'h0000_0101,  32'h0000_0100};
    vecs[7] = '{"jalr_top",   2'b10, 32'h0,         32'hFFFF_FFFC,  32'hFFFF_FFFC};
    vecs[8] = '{"seq_wrap",   2'b00, 32'h0,         32'h0,          32'h0000_0000};
    vecs[9] = '{"jal_0x100",  2'b01, 32'h0000_0100, 32'h0,          32'h0000_0100};

    // Reset state, with an ack held active throughout reset
    ack_force = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_pc", pc, 32'h0);
    check("rst_trap", {30'h0, trap_cause}, 32'h0);
    check("rst_pc_plus4", pc_plus4, 32'h4);
    ack_force = 1'b0;
    rst_n = 1'b1;
    check("idle_req", 32'(imem_req), 32'd0);
    exp_q.push_back(32'h0);
    @(negedge clk);
    check("first_req", 32'(imem_req), 32'd1);
    check("first_addr", imem_addr, 32'h0);
    check("first_valid", 32'(instr_valid), 32'd0);
    wait_valid(cyc);
    check("first_latency", 32'(cyc), 32'd1);
    sb_pop("first");
    check("first_instr_const", instr, 32'h0050_0093);

    // Ack while idle in S_VALID must not disturb the held instruction
    ack_force = 1'b1;
    @(negedge clk);
    ack_force = 1'b0;
    check("stray_ack_instr", instr, 32'h0050_0093);
    check("stray_ack_valid", 32'(instr_valid), 32'd1);
    check("stray_ack_req", 32'(imem_req), 32'd0);

    for (int i = 0; i < 10; i++)
      step(vecs[i].name, vecs[i].src, vecs[i].imm, vecs[i].alu, vecs[i].exp_pc);

    // Misaligned jalr target: pc stays, sticky trap with cause 01
    pulse(2'b10, 32'h0, 32'h0000_0203);
    check("mis_trap", 32'(trap), 32'd1);
    check("mis_cause", {30'h0, trap_cause}, 32'h1);
    check("mis_pc", pc, 32'h0000_0100);
    check("mis_req", 32'(imem_req), 32'd0);
    check("mis_valid", 32'(instr_valid), 32'd0);
    ack_force = 1'b1;
    pulse(2'b00, 32'h0, 32'h0);
    pulse(2'b10, 32'h0, 32'h0000_0003);
    ack_force = 1'b0;
    check("mis_sticky_pc", pc, 32'h0000_0100);
    check("mis_sticky_cause", {30'h0, trap_cause}, 32'h1);
    check("mis_sticky_req", 32'(imem_req), 32'd0);
    check("mis_sticky_valid", 32'(instr_valid), 32'd0);

    // Async reset in the middle of a pending request
    rst_n = 1'b0;
    @(negedge clk);
    check("rst2_trap", 32'(trap), 32'd0);
    rst_n = 1'b1;
    exp_q.push_back(32'h0);
    wait_valid(cyc);
    check("rst2_latency", 32'(cyc), 32'd2);
    sb_pop("rst2");
    step("jal_0x40", 2'b01, 32'h0000_0040, 32'h0, 32'h0000_0040);
    ack_auto = 1'b0;
    pulse(2'b00, 32'h0, 32'h0);
    check("mid_pc", pc, 32'h0000_0044);
    check("mid_req", 32'(imem_req), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_req", 32'(imem_req), 32'd0);
    check("async_pc", pc, 32'h0);
    check("async_instr", instr, 32'h0);
    check("async_valid", 32'(instr_valid), 32'd0);

    // Timeout: no ack for 16 request cycles
    @(negedge clk);
    rst_n = 1'b1;
    req_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (trap) break;
      if (imem_req) req_cycles++;
    end
    check("to_req_cycles", 32'(req_cycles), 32'd16);
    check("to_trap", 32'(trap), 32'd1);
    check("to_cause", {30'h0, trap_cause}, 32'h2);
    check("to_req_low", 32'(imem_req), 32'd0);
    ack_force = 1'b1;
    pulse(2'b01, 32'h0000_0008, 32'h0);
    ack_force = 1'b0;
    pulse(2'b10, 32'h0, 32'h0000_0002);
    check("to_sticky_cause", {30'h0, trap_cause}, 32'h2);
    check("to_sticky_pc", pc, 32'h0);
    check("to_sticky_valid", 32'(instr_valid), 32'd0);
    check("to_sticky_instr", instr, 32'h0);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Instruction-fetch and PC sequencing stage upstream of the control/decode logic.
- Holds the architectural PC and fetches the instruction word over a req/ack instruction-memory interface.
- Presents the instruction with instr_valid to decode/control.
- Computes the next PC from the pc_src select, branch/jump immediate and ALU result produced downstream.
- Detects misaligned targets and memory timeouts, entering a sticky trap.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
TIMEOUT, 16, max cycles in S_REQ waiting for imem_ack before bus error (range 2..255)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
pc_src  input  2  next-PC select from control: 00 PC+4, 01 PC+imm_ext, 10 jalr target, 11 reserved (treated as 00)
imm_ext  input  32  sign-extended branch/jal immediate
alu_result  input  32  jalr target from ALU
exec_done  input  1  datapath has committed the current instruction; advance PC
imem_req  output  1  fetch request
imem_addr  output  32  fetch address, word aligned
imem_ack  input  1  fetch data valid this cycle
imem_rdata  input  32  fetched instruction
instr  output  32  held instruction to decode
instr_valid  output  1  instr is valid and awaiting exec_done
pc  output  32  current PC
pc_plus4  output  32  pc + 4, combinational
trap  output  1  sticky: fetch halted
trap_cause  output  2  00 none, 01 misaligned target, 10 imem timeout

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=S_IDLE, instr=0, instr_valid=0, imem_req=0, trap=0, trap_cause=00, timeout counter=0.
  - Outputs drop immediately on assertion, even mid-request; an ack arriving during reset is ignored.
- States:
  - S_IDLE: one cycle after reset release; goes to S_REQ.
  - S_REQ:
    - imem_req=1, imem_addr=pc; counter increments each cycle.
    - On imem_ack (may arrive in the first S_REQ cycle): instr<=imem_rdata, counter<=0, go S_VALID.
    - If counter reaches TIMEOUT-1 without ack: trap<=1, trap_cause<=10, go S_TRAP.
  - S_VALID:
    - instr_valid=1, imem_req=0; instr and pc stable.
    - On exec_done: pc<=next_pc, go S_REQ.
    - exec_done outside S_VALID is ignored.
  - S_TRAP: imem_req=0, instr_valid=0, pc frozen; exit only via reset.
- next_pc, all 32-bit modulo 2^32, wrap silently:
  - pc_src 00/11: pc+4.
  - 01: pc+imm_ext.
  - 10: {alu_result[31:1],1'b0}.
- Misalign check:
  - If next_pc[1:0]!=00 at exec_done: pc NOT updated, trap<=1, trap_cause<=01, go S_TRAP.
  - The offending instruction has already committed.
- Latency:
  - exec_done at cycle t -> new pc and imem_req at t+1.
  - With ack at t+1, instr_valid=1 at t+2.
- imem_ack while imem_req=0 is ignored.
- imem_addr=pc at all times; meaningful only when imem_req=1.
- trap_cause is written once; later events cannot change it.

Test Plan:
- Reset with RESET_PC=0: release rst_n, ack after 1 cycle with 32'h00500093 -> imem_req first high 1 cycle after release at addr 0; instr_valid=1 and instr=32'h00500093 on the next cycle.
- Sequential: exec_done with pc_src=00 at pc=0x10 -> pc=0x14, imem_addr=0x14 next cycle; pc_src=11 also gives 0x14.
- Branch/jalr: pc=0x100, pc_src=01, imm_ext=0xFFFFFFF0 -> pc=0xF0; pc_src=10, alu_result=0x203 -> pc=0x202 -> trap=1, trap_cause=01, pc stays 0x100.
- Timeout: TIMEOUT=16, hold imem_ack=0 -> trap=1, trap_cause=10 after 16 S_REQ cycles; imem_req=0 thereafter; later ack and exec_done have no effect.
- Wrap/async reset: pc=0xFFFFFFFC, pc_src=00 -> pc=0x0. Then assert rst_n=0 mid-S_REQ -> imem_req=0 and pc=RESET_PC within the same cycle, no clock edge required.
